// File: rtl/fcpu_pkg.sv
// Shared fcpu core definitions: tag/data widths, CDB layout and the
// reorder buffer entry record.
package fcpu_pkg;

    localparam int RSV_ID_W   = 3;
    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CDB_W      = RSV_ID_W + DATA_W;

    // One in-flight instruction awaiting in-order retirement.
    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / retirement signal bundle of the reorder buffer.
// The master side is dispatch plus the register file; the slave side is the buffer.
interface reorder_buffer_if
    import fcpu_pkg::*;
#(
    parameter int REG_ADDR_W = fcpu_pkg::REG_ADDR_W
) ();

    logic                  alloc_valid;
    logic [REG_ADDR_W-1:0] alloc_dest;
    logic                  alloc_ready;
    logic [RSV_ID_W-1:0]   alloc_id;

    logic                  cdb_valid;
    logic [CDB_W-1:0]      cdb;

    logic [RSV_ID_W-1:0]   rd_id;
    logic                  rd_filled;
    logic [DATA_W-1:0]     rd_data;

    logic                  commit_valid;
    logic [RSV_ID_W-1:0]   commit_id;
    logic [REG_ADDR_W-1:0] commit_dest;
    logic [DATA_W-1:0]     commit_data;
    logic                  commit_ready;

    logic                  flush;
    logic [RSV_ID_W:0]     count;

    modport master (
        output alloc_valid, alloc_dest, cdb_valid, cdb, rd_id, commit_ready, flush,
        input  alloc_ready, alloc_id, rd_filled, rd_data,
               commit_valid, commit_id, commit_dest, commit_data, count
    );

    modport slave (
        input  alloc_valid, alloc_dest, cdb_valid, cdb, rd_id, commit_ready, flush,
        output alloc_ready, alloc_id, rd_filled, rd_data,
               commit_valid, commit_id, commit_dest, commit_data, count
    );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: hands out tags at the tail, captures CDB results
// out of order and retires completed entries from the head.
module reorder_buffer
    import fcpu_pkg::*;
#(
    parameter int REG_ADDR_W = fcpu_pkg::REG_ADDR_W
) (
    input  logic           clk,
    input  logic           nrst,
    reorder_buffer_if.slave rob
);

    localparam int DEPTH = 1 << RSV_ID_W;
    localparam int PTR_W = RSV_ID_W + 1;

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [PTR_W-1:0]    countVal;
    logic [RSV_ID_W-1:0] headIdx;
    logic [RSV_ID_W-1:0] tailIdx;
    logic [RSV_ID_W-1:0] cdbTag;
    logic [DATA_W-1:0]   cdbData;
    logic                full;
    logic                allocFire;
    logic                commitFire;
    logic                cdbFire;
    rob_entry_t          headEntry;
    rob_entry_t          cdbEntry;
    rob_entry_t          rdEntry;

    assign headIdx  = head_q[RSV_ID_W-1:0];
    assign tailIdx  = tail_q[RSV_ID_W-1:0];
    assign cdbTag   = rob.cdb[DATA_W +: RSV_ID_W];
    assign cdbData  = rob.cdb[0 +: DATA_W];

    // Wrap bit makes the modular difference distinguish full from empty.
    assign countVal = tail_q - head_q;
    assign full     = (countVal == PTR_W'(DEPTH));

    assign headEntry = entries_q[headIdx];
    assign cdbEntry  = entries_q[cdbTag];
    assign rdEntry   = entries_q[rob.rd_id];

    assign rob.alloc_ready  = !nrst && !rob.flush && !full;
    assign rob.alloc_id     = tailIdx;
    assign rob.count        = countVal;

    assign rob.commit_valid = !nrst && !rob.flush && headEntry.valid && headEntry.done;
    assign rob.commit_id    = headIdx;
    assign rob.commit_dest  = headEntry.dest;
    assign rob.commit_data  = headEntry.data;

    assign allocFire  = rob.alloc_valid && rob.alloc_ready;
    assign commitFire = rob.commit_valid && rob.commit_ready;
    assign cdbFire    = rob.cdb_valid && cdbEntry.valid && !cdbEntry.done;

    // Operand lookup, with a same-cycle bypass from the CDB so dispatch never
    // misses a result that is being broadcast right now.
    always_comb begin
        rob.rd_filled = rdEntry.valid && rdEntry.done;
        rob.rd_data   = rdEntry.data;
        if (rob.cdb_valid && (cdbTag == rob.rd_id) && rdEntry.valid) begin
            rob.rd_filled = 1'b1;
            rob.rd_data   = cdbData;
        end
    end

    // Allocation is applied last so it overrides a CDB write to the same slot.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (cdbFire) begin
            entries_d[cdbTag].done = 1'b1;
            entries_d[cdbTag].data = cdbData;
        end
        if (commitFire) begin
            entries_d[headIdx] = '0;
            head_d             = head_q + 1'b1;
        end
        if (allocFire) begin
            entries_d[tailIdx].valid = 1'b1;
            entries_d[tailIdx].done  = 1'b0;
            entries_d[tailIdx].dest  = rob.alloc_dest;
            entries_d[tailIdx].data  = '0;
            tail_d                   = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (nrst || rob.flush) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

endmodule
